lcd_ctrl: RTL and testbench



---
 rtl/lcd_ctrl_if.sv | 23 ++
 rtl/lcd_ctrl.sv | 131 +++++++++++++
 tb/tb_lcd_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: command/data and display handshake bundle for lcd_ctrl.
//   datain       : pixel data from the source, used only while loading
//   cmd          : 3-bit command code
//   cmd_valid    : command strobe, honoured only while busy is low
//   dataout      : window pixel to the display sink
//   output_valid : dataout qualifier, high for the 9 pixels of each command
//   busy         : high from command acceptance until the output completes
// master = command source / display sink side, slave = the controller.
interface lcd_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] datain;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    modport master (output datain, cmd, cmd_valid,
                    input  dataout, output_valid, busy);
    modport slave  (input  datain, cmd, cmd_valid,
                    output dataout, output_valid, busy);
endinterface

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: 6x6 image store with a movable 3x3 display window.
// Each accepted command (load, shift, reflash) finishes by streaming the
// 9 window pixels in row-major order, one per cycle, with output_valid.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any command in flight
//   bus   : lcd_ctrl_if.slave (datain, cmd, cmd_valid, dataout,
//           output_valid, busy)
module lcd_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int WIN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    lcd_ctrl_if.slave  bus
);
    localparam int NPIX = IMG_W * IMG_W;
    localparam int NOUT = WIN * WIN;
    localparam int AW   = $clog2(NPIX);
    localparam int OW   = $clog2(IMG_W - WIN + 1);
    localparam int KW   = $clog2(NOUT + 1);
    localparam int WW   = $clog2(WIN);

    localparam logic [OW-1:0] OMAX  = OW'(IMG_W - WIN);
    localparam logic [OW-1:0] OHOME = OW'(2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_UP    = 3'd4;
    localparam logic [2:0] CMD_DOWN  = 3'd5;

    logic [DW-1:0] mem [NPIX];

    logic [1:0]    state;
    logic [AW-1:0] cnt;       // load write address
    logic [KW-1:0] k;         // output index; k == NOUT is the closing edge
    logic [WW-1:0] wr, wc;    // window row/col of pixel k
    logic [OW-1:0] ox, oy;    // window origin
    logic [DW-1:0] dout;
    logic          ov;
    logic          busy_q;
    logic [AW-1:0] rd_addr;

    assign bus.dataout      = dout;
    assign bus.output_valid = ov;
    assign bus.busy         = busy_q;

    always_comb begin
        rd_addr = AW'((int'(oy) + int'(wr)) * IMG_W + int'(ox) + int'(wc));
    end

    // Image store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && state == S_LOAD)
            mem[cnt] <= bus.datain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            ov     <= 1'b0;
            dout   <= '0;
            ox     <= OHOME;
            oy     <= OHOME;
            cnt    <= '0;
            k      <= '0;
            wr     <= '0;
            wc     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        k      <= '0;
                        wr     <= '0;
                        wc     <= '0;
                        if (bus.cmd == CMD_LOAD) begin
                            state <= S_LOAD;
                        end else begin
                            // Out-of-range shifts hold the origin but still
                            // produce a full window.
                            state <= S_OUT;
                            case (bus.cmd)
                                CMD_RIGHT: if (ox != OMAX) ox <= ox + 1'b1;
                                CMD_LEFT:  if (ox != '0)   ox <= ox - 1'b1;
                                CMD_UP:    if (oy != '0)   oy <= oy - 1'b1;
                                CMD_DOWN:  if (oy != OMAX) oy <= oy + 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                S_LOAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NPIX - 1)) begin
                        ox    <= OHOME;
                        oy    <= OHOME;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (k == KW'(NOUT)) begin
                        ov     <= 1'b0;
                        dout   <= '0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        dout <= mem[rd_addr];
                        ov   <= 1'b1;
                        k    <= k + 1'b1;
                        if (wc == WW'(WIN - 1)) begin
                            wc <= '0;
                            wr <= (wr == WW'(WIN - 1)) ? '0 : wr + 1'b1;
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for lcd_ctrl. The reference model keeps the
// image as a flat array and the origin as two integers; each command pushes
// its 9 expected window pixels into a queue that a negedge monitor drains.
module tb_lcd_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    lcd_ctrl_if #(.DW(8)) bus();

    lcd_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] img[36];
    logic [7:0] new_img[36];
    int ox = 2, oy = 2;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Monitor: every valid output must match the oldest expected pixel;
    // dataout must read zero whenever it is not valid.
    always @(negedge clk) begin
        if (started) begin
            if (bus.output_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("pixel", int'(bus.dataout), int'(e));
                end
            end else begin
                check("dataout_idle_zero", int'(bus.dataout), 0);
            end
        end
    end

    function automatic void model_cmd(input logic [2:0] c);
        case (c)
            3'd1: begin
                for (int i = 0; i < 36; i++) img[i] = new_img[i];
                ox = 2; oy = 2;
            end
            3'd2: if (ox < 3) ox++;
            3'd3: if (ox > 0) ox--;
            3'd4: if (oy > 0) oy--;
            3'd5: if (oy < 3) oy++;
            default: ;
        endcase
        for (int r = 0; r < 3; r++)
            for (int cc = 0; cc < 3; cc++)
                exp_q.push_back(img[(oy + r) * 6 + ox + cc]);
    endfunction

    // Issue one command at a negedge with busy low; counts busy cycles and
    // output latency, feeds load data, and pokes cmd_valid while busy.
    // abort_at > 0 asserts reset once that many outputs have been seen.
    task automatic issue(input logic [2:0] c, input int abort_at);
        int n, nvalid, busy_cyc, first_v;
        bit is_load;
        is_load = (c == 3'd1);
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            check("idle_timeout", 1, 0);
            return;
        end
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        model_cmd(c);
        n = 0; nvalid = 0; busy_cyc = 0; first_v = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_cyc++;
            if (bus.output_valid) begin
                nvalid++;
                if (first_v == 0) first_v = n;
            end
            if (is_load && n <= 36) bus.datain = new_img[n-1];
            else bus.datain = 8'($urandom);
            if (bus.busy && $urandom_range(0, 1) == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd = 3'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (abort_at > 0 && nvalid == abort_at) begin
                bus.cmd_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("abort_valid", int'(bus.output_valid), 0);
                check("abort_busy", int'(bus.busy), 0);
                exp_q.delete();
                ox = 2; oy = 2;
                return;
            end
        end while ((bus.busy || n < 2) && n < 100);
        if (n >= 100) check("cmd_timeout", 1, 0);
        check(is_load ? "load_busy_cycles" : "busy_cycles", busy_cyc, is_load ? 46 : 10);
        check(is_load ? "load_first_valid" : "first_valid", first_v, is_load ? 38 : 2);
        check("valid_count", nvalid, 9);
    endtask

    initial begin
        logic [2:0] dirs[$];
        bus.datain = '0;
        bus.cmd = '0;
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.output_valid), 0);
        check("rst_dataout", int'(bus.dataout), 0);
        reset = 1'b0;
        started = 1'b1;

        // Identity image, then the directed shift walks including saturation.
        for (int i = 0; i < 36; i++) new_img[i] = 8'(i);
        issue(3'd1, 0);
        dirs = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5,
                 3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd2, 3'd2, 3'd4,
                 3'd0, 3'd6, 3'd7};
        foreach (dirs[i]) issue(dirs[i], 0);

        // Random images and random command streams.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 36; i++) new_img[i] = 8'($urandom);
            issue(3'd1, 0);
            for (int j = 0; j < 20; j++) begin
                logic [2:0] c;
                c = 3'($urandom);
                if (c == 3'd1) c = 3'd0;
                issue(c, 0);
            end
        end

        // Reset mid-output, then a reflash from the retained image.
        for (int i = 0; i < 36; i++) new_img[i] = 8'(i);
        issue(3'd1, 0);
        issue(3'd2, 0);
        issue(3'd0, 5);
        issue(3'd0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
